gbprocessor_probe_collector: RTL
================================

Name: gbprocessor_probe_collector

Overview:
Capture block on the result side of the gbprocessor interface. It samples the processor's probe output on every valid cycle and tags each sample with a sequence number. Tagged samples are buffered in a FWFT FIFO that a checker or bench drains over a valid/ready read port. It sits beside gbprocessor and is the consuming end of the probe/valid pair, while the stimulus side drives instruction.

Parameters:
PROBE_WIDTH, 8, width of probe bus from gbprocessor
DEPTH, 16, FIFO entries; power of two, >= 2
STOP_ON_FULL, 0, 1 = enter HALTED on first dropped sample; 0 = keep capturing and count drops

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
valid  input  1  gbprocessor result-valid strobe
probe  input  PROBE_WIDTH  gbprocessor probe value, sampled when valid=1
arm  input  1  pulse: IDLE->CAPTURE
disarm  input  1  pulse: any state->IDLE
clear  input  1  flush FIFO and counters
rd_data  output  PROBE_WIDTH+8  {seq[7:0], probe}
rd_valid  output  1  FIFO not empty
rd_ready  input  1  consumer accepts rd_data
level  output  $clog2(DEPTH)+1  current FIFO occupancy
captured_count  output  16  accepted samples, saturating
dropped_count  output  16  samples lost to full FIFO, saturating
state  output  2  0=IDLE, 1=CAPTURE, 2=HALTED

Behaviour:
- Reset (sync, active-high): state=IDLE; pointers, level, seq, captured_count and dropped_count=0; rd_valid=0; rd_data=0. Reset overrides all other inputs.
- FSM:
  - IDLE: arm -> CAPTURE, and seq is cleared to 0 on that edge.
  - CAPTURE: disarm -> IDLE. If STOP_ON_FULL=1 and a drop occurs -> HALTED.
  - HALTED: only disarm exits, to IDLE.
  - arm in CAPTURE or HALTED is ignored.
  - arm and disarm in the same cycle: disarm wins.
- Sample event: state==CAPTURE && valid==1. Samples outside CAPTURE are ignored, with no counter change.
- Push accept = sample event && (!full || pop this cycle). The entry written is {seq, probe}, captured_count+1 (saturates at 16'hFFFF), and it becomes visible on rd_* the next cycle.
- Drop = sample event && full && no pop. dropped_count+1 (saturating). No write occurs.
- seq increments by 1 on every sample event, accepted or dropped, wrapping 255->0. Gaps in seq therefore expose drops.
- Read side is FWFT:
  - rd_valid = (level != 0).
  - rd_data = head entry when rd_valid=1, else 0.
  - Pop = rd_valid && rd_ready; the head advances next cycle.
- Push and pop in the same cycle: level is unchanged. This is legal when full (slot freed) and when level=1. When empty no pop is possible, so push alone applies.
- level updates one cycle after the push/pop edge. Maximum level is DEPTH.
- Pointers wrap modulo DEPTH; the full/empty distinction uses an extra pointer bit.
- clear (any state): on the next edge, pointers, level, seq and both counters = 0. state is unchanged. clear beats a simultaneous push or pop, and that sample is discarded without counting.
- Reset mid-capture discards FIFO contents. rd_valid is 0 the cycle after reset.
- Latency from a valid sample to rd_valid rising is 1 cycle (from empty).

Test Plan:
- Reset, arm, then drive valid=1 for 4 cycles with probe=8'h10..8'h13, rd_ready=0 -> level=4, captured_count=4; rd_data sequence on drain = 16'h0010, 16'h0111, 16'h0212, 16'h0313.
- DEPTH=16, STOP_ON_FULL=0, 20 valid samples, rd_ready=0 -> level=16, captured_count=16, dropped_count=4, state=CAPTURE; next accepted sample after one pop carries seq=20.
- STOP_ON_FULL=1, 17 valid samples -> state=HALTED after the 17th, dropped_count=1; further valid ignored (dropped_count stays 1); disarm -> IDLE.
- FIFO full, then valid=1 and rd_ready=1 in the same cycle -> push accepted, level stays 16, dropped_count unchanged.
- valid=1 while IDLE or before arm -> level=0, seq=0, counters 0. Then clear asserted concurrently with a sample in CAPTURE -> level=0, captured_count=0 next cycle.
- Assert reset with level=5 mid-capture -> next cycle state=IDLE, rd_valid=0, rd_data=0, all counters 0.

Source files
------------

// File: rtl/gbprocessor_probe_collector.sv
`default_nettype none
// ============================================================================
//  Module   : gbprocessor_probe_collector
//  Brief    : Captures gbprocessor probe samples on valid strobes, tags each
//             with an 8-bit sequence number, and buffers them in a
//             first-word-fall-through FIFO drained over a valid/ready port.
//  Revision : 1.0  initial release
// ============================================================================
module gbprocessor_probe_collector #(
    parameter int PROBE_WIDTH  = 8,
    parameter int DEPTH        = 16,
    parameter int STOP_ON_FULL = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       valid,
    input  logic [PROBE_WIDTH-1:0]     probe,
    input  logic                       arm,
    input  logic                       disarm,
    input  logic                       clear,
    output logic [PROBE_WIDTH+8-1:0]   rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                captured_count,
    output logic [15:0]                dropped_count,
    output logic [1:0]                 state
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = PROBE_WIDTH + 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [7:0]      seq_q, seq_d;
    logic [15:0]     cap_q, cap_d;
    logic [15:0]     drop_q, drop_d;
    logic [DW-1:0]   mem_q [DEPTH];

    logic [AW:0]     w_level;
    logic            w_full;
    logic            w_empty;
    logic            w_sample;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_arm_go;

    // Occupancy comes from the pointer difference; the extra MSB separates full from empty
    assign w_level  = wr_ptr_q - rd_ptr_q;
    assign w_empty  = (w_level == '0);
    assign w_full   = (w_level == (AW+1)'(DEPTH));

    // Sample qualification; clear discards whatever happens on its cycle
    assign w_sample = (state_q == ST_CAPTURE) && valid;
    assign w_pop    = !w_empty && rd_ready && !clear;
    assign w_push   = w_sample && (!w_full || (!w_empty && rd_ready)) && !clear;
    assign w_drop   = w_sample && w_full && !rd_ready && !clear;
    assign w_arm_go = (state_q == ST_IDLE) && arm && !disarm;

    // Next-state logic: disarm always returns to IDLE and beats arm
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (arm) state_d = ST_CAPTURE;
            ST_CAPTURE: if ((STOP_ON_FULL != 0) && w_drop) state_d = ST_HALTED;
            ST_HALTED:  state_d = ST_HALTED;
            default:    state_d = ST_IDLE;
        endcase
        if (disarm) state_d = ST_IDLE;
    end

    // Datapath next values: pointers, sequence tag and saturating counters
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        seq_d    = seq_q;
        cap_d    = cap_q;
        drop_d   = drop_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            seq_d    = '0;
            cap_d    = '0;
            drop_d   = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            // Every sample event consumes a tag so gaps reveal drops
            if (w_arm_go)      seq_d = '0;
            else if (w_sample) seq_d = seq_q + 8'd1;
            if (w_push && (cap_q != 16'hFFFF))  cap_d  = cap_q + 16'd1;
            if (w_drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
        end
    end

    // Control and counter registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            seq_q    <= '0;
            cap_q    <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            seq_q    <= seq_d;
            cap_q    <= cap_d;
            drop_q   <= drop_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility
    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {seq_q, probe};
        end
    end

    assign rd_valid       = !w_empty;
    assign rd_data        = w_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign level          = w_level;
    assign captured_count = cap_q;
    assign dropped_count  = drop_q;
    assign state          = state_q;

endmodule
`default_nettype wire
